// File: rtl/hamming_secded_decoder_pipe.sv
// hamming_secded_decoder_pipe: two-stage SEC-DED Hamming decoder with valid/ready flow; HAMDEC_ERR_CNT_EN adds saturating error counters
module hamming_secded_decoder_pipe #(
  parameter int DATA_W = 4,
  parameter int CNT_W = 16,
  localparam int R = DATA_W <= 4 ? 3 : DATA_W <= 11 ? 4 : DATA_W <= 26 ? 5 : DATA_W <= 57 ? 6 : 7,
  localparam int N = DATA_W + R
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N:0]        in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [R-1:0]      out_syndrome,
  output logic              out_corrected,
  output logic              out_uncorrectable,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corrected,
  output logic [CNT_W-1:0]  cnt_uncorrectable
);
  function automatic int data_pos(input int k);
    int p, c;
    p = 0;
    c = -1;
    while (c < k) begin
      p++;
      if ((p & (p - 1)) != 0) c++;
    end
    return p;
  endfunction
  logic              adv, s1_valid, s1_par, par, flip, syn_ok, corr, unc;
  logic [N-1:0]      s1_code, fixed;
  logic [R-1:0]      s1_syn, syn;
  logic [DATA_W-1:0] data;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign par = ^in_code;
  always_comb begin
    syn = '0;
    for (int i = 1; i <= N; i++) syn ^= in_code[i-1] ? R'(i) : '0;
  end
  assign syn_ok = int'(s1_syn) <= N;
  assign corr = s1_par && syn_ok;
  assign unc = s1_par ? !syn_ok : s1_syn != '0;
  assign flip = corr && s1_syn != '0;
  always_comb begin
    for (int i = 0; i < N; i++) fixed[i] = s1_code[i] ^ (flip && s1_syn == R'(i + 1));
  end
  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    localparam int P = data_pos(k);
    assign data[k] = fixed[P-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code <= '0;
      s1_syn <= '0;
      s1_par <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_syndrome <= '0;
      out_corrected <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_code <= in_code[N-1:0];
        s1_syn <= syn;
        s1_par <= par;
      end
      if (s1_valid) begin
        out_data <= data;
        out_syndrome <= s1_syn;
        out_corrected <= corr;
        out_uncorrectable <= unc;
      end
    end
  end
`ifdef HAMDEC_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corrected <= '0;
      cnt_uncorrectable <= '0;
    end else if (cnt_clr) begin
      cnt_corrected <= '0;
      cnt_uncorrectable <= '0;
    end else if (out_valid && out_ready) begin
      if (out_corrected && !(&cnt_corrected)) cnt_corrected <= cnt_corrected + CNT_W'(1);
      if (out_uncorrectable && !(&cnt_uncorrectable)) cnt_uncorrectable <= cnt_uncorrectable + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_corrected = '0;
  assign cnt_uncorrectable = '0;
`endif
endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// tb_hamming_secded_decoder_pipe: random and directed streams into 4-bit and 32-bit decoders against a flip-set reference model
module tb_hamming_secded_decoder_pipe;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  syn;
    logic        corr;
    logic        unc;
  } exp_t;
`ifdef HAMDEC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 0, rst_n = 0, out_ready = 1, cnt_clr = 0;
  logic in_valid4 = 0, in_ready4, out_valid4, corr4, unc4;
  logic [7:0] in_code4 = '0;
  logic [3:0] data4;
  logic [2:0] syn4;
  logic [1:0] cc4, cu4;
  logic in_valid32 = 0, in_ready32, out_valid32, corr32, unc32;
  logic [38:0] in_code32 = '0;
  logic [31:0] data32;
  logic [5:0] syn32;
  logic [15:0] cc32, cu32;
  int n_checks = 0, n_errors = 0, stall_left = 0;
  bit rand_rdy = 0, hold_low = 0, stalled4 = 0;
  logic [8:0] prev4 = '0;
  exp_t q4[$], q32[$];
  always #5 clk = ~clk;
  hamming_secded_decoder_pipe #(.DATA_W(4), .CNT_W(2)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_code(in_code4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(data4), .out_syndrome(syn4),
    .out_corrected(corr4), .out_uncorrectable(unc4), .cnt_clr(cnt_clr),
    .cnt_corrected(cc4), .cnt_uncorrectable(cu4));
  hamming_secded_decoder_pipe #(.DATA_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32), .in_code(in_code32),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(data32), .out_syndrome(syn32),
    .out_corrected(corr32), .out_uncorrectable(unc32), .cnt_clr(cnt_clr),
    .cnt_corrected(cc32), .cnt_uncorrectable(cu32));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int r_of(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction
  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction
  function automatic logic [71:0] encode(input int dw, input logic [63:0] d);
    int n, j;
    logic b;
    logic [71:0] c;
    n = dw + r_of(dw);
    j = 0;
    c = '0;
    for (int p = 1; p <= n; p++)
      if (!is_pow2(p)) begin
        c[p-1] = d[j];
        j++;
      end
    for (int k = 0; (1 << k) <= n; k++) begin
      b = 0;
      for (int p = 1; p <= n; p++) if (((p >> k) & 1) == 1) b ^= c[p-1];
      c[(1 << k) - 1] = b;
    end
    c[n] = ^c;
    return c;
  endfunction
  function automatic logic [63:0] extract(input int dw, input logic [71:0] c);
    int j;
    logic [63:0] d;
    j = 0;
    d = '0;
    for (int p = 1; p <= dw + r_of(dw); p++)
      if (!is_pow2(p)) begin
        d[j] = c[p-1];
        j++;
      end
    return d;
  endfunction
  function automatic exp_t mk(input logic [63:0] d, input int s, input bit c, input bit u);
    exp_t e;
    e.data = d;
    e.syn = 8'(s);
    e.corr = c;
    e.unc = u;
    return e;
  endfunction
  // Expected outputs follow from which positions were flipped, not from the received bits.
  function automatic void model(input int dw, input logic [63:0] d, input logic [71:0] fl,
                                output logic [71:0] code, output exp_t e);
    int n, s, nf;
    logic [71:0] c;
    n = dw + r_of(dw);
    c = encode(dw, d) ^ fl;
    s = 0;
    nf = 0;
    for (int p = 1; p <= n + 1; p++)
      if (fl[p-1]) begin
        nf++;
        if (p <= n) s ^= p;
      end
    code = c;
    e = mk('0, s, 0, 0);
    if (nf % 2 == 1 && s <= n) begin
      e.corr = 1;
      if (s != 0) c[s-1] ^= 1'b1;
    end else if (s != 0) e.unc = 1;
    e.data = extract(dw, c);
  endfunction
  function automatic logic [71:0] rand_flips(input int total, input int k);
    logic [71:0] m;
    int cnt, p;
    m = '0;
    cnt = 0;
    while (cnt < k) begin
      p = $urandom_range(0, total - 1);
      if (!m[p]) begin
        m[p] = 1'b1;
        cnt++;
      end
    end
    return m;
  endfunction
  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input bit w, input logic [71:0] code, input exp_t e);
    bit ok;
    ok = 0;
    if (w) begin
      in_valid32 = 1;
      in_code32 = code[38:0];
    end else begin
      in_valid4 = 1;
      in_code4 = code[7:0];
    end
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (w ? in_ready32 : in_ready4) begin
        ok = 1;
        if (w) q32.push_back(e);
        else q4.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid4 = 0;
    in_valid32 = 0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask
  task automatic sendm(input bit w, input logic [63:0] d, input logic [71:0] fl);
    logic [71:0] c;
    exp_t e;
    model(w ? 32 : 4, d, fl, c, e);
    send(w, c, e);
  endtask
  task automatic drain();
    int t;
    t = 0;
    while ((q4.size() != 0 || q32.size() != 0) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", 64'(q4.size() + q32.size()), 0);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        out_ready = 0;
        stall_left--;
      end else if (hold_low) out_ready = 0;
      else out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) stalled4 = 0;
    else begin
      if (stalled4) begin
        check("hold_out4", {out_valid4, data4, syn4, corr4, unc4}, {1'b1, prev4});
      end
      if (out_valid4 && !out_ready) check("stall_in_ready4", in_ready4, 0);
      if (out_valid4 && out_ready) begin
        if (q4.size() == 0) check("unexpected_out4", 1, 0);
        else begin
          e = q4.pop_front();
          check("data4", data4, e.data);
          check("syn4", syn4, e.syn);
          check("flags4", {corr4, unc4}, {e.corr, e.unc});
        end
      end
      if (out_valid32 && out_ready) begin
        if (q32.size() == 0) check("unexpected_out32", 1, 0);
        else begin
          e = q32.pop_front();
          check("data32", data32, e.data);
          check("syn32", syn32, e.syn);
          check("flags32", {corr32, unc32}, {e.corr, e.unc});
        end
      end
      stalled4 = out_valid4 && !out_ready;
      prev4 = {data4, syn4, corr4, unc4};
    end
  end
  initial begin
    idle(3);
    check("rst_out4", {out_valid4, data4, syn4, corr4, unc4, in_ready4}, 64'h1);
    check("rst_out32", {out_valid32, data32, syn32, corr32, unc32}, 0);
    check("rst_cnt", {cc4, cu4, cc32, cu32}, 0);
    @(posedge clk);
    #3 rst_n = 1;
    idle(1);
    send(0, 72'h55, mk(64'hB, 0, 0, 0));
    send(0, 72'h45, mk(64'hB, 5, 1, 0));
    send(0, 72'hD5, mk(64'hB, 0, 1, 0));
    send(0, 72'h56, mk(64'hB, 3, 0, 1));
    drain();
    for (int i = 0; i < 8; i++) begin
      sendm(0, 64'($urandom_range(0, 15)), rand_flips(8, $urandom_range(0, 2)));
      if (i == 3) stall_left = 3;
    end
    drain();
    rand_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(0, 2));
      sendm(0, 64'($urandom_range(0, 15)), rand_flips(8, $urandom_range(0, 2)));
    end
    drain();
    for (int p = 1; p <= 39; p++) sendm(1, 64'($urandom), 72'(1) << (p - 1));
    sendm(1, 64'($urandom), (72'(1) << 0) | (72'(1) << 37));
    sendm(1, 64'($urandom), (72'(1) << 7) | (72'(1) << 15) | (72'(1) << 31));
    for (int i = 0; i < 30; i++) begin
      idle($urandom_range(0, 1));
      sendm(1, 64'($urandom), rand_flips(39, $urandom_range(0, 3)));
    end
    drain();
    rand_rdy = 0;
    hold_low = 1;
    idle(2);
    sendm(0, 64'h9, 0);
    sendm(0, 64'h6, 72'h4);
    check("inflight4", out_valid4, 1);
    #2 rst_n = 0;
    #1;
    check("rst_mid4", {out_valid4, data4, syn4, corr4, unc4}, 0);
    q4.delete();
    q32.delete();
    @(posedge clk);
    #3 rst_n = 1;
    hold_low = 0;
    idle(6);
    check("post_rst_idle4", {out_valid4, out_valid32}, 0);
    check("cnt_after_rst", {cc4, cu4}, 0);
    for (int i = 0; i < 5; i++) sendm(0, 64'($urandom_range(0, 15)), rand_flips(8, 1));
    drain();
    idle(1);
    check("cnt_corr_sat", cc4, CNT_EN ? 64'd3 : 64'd0);
    check("cnt_unc", cu4, 0);
    cnt_clr = 1;
    idle(1);
    cnt_clr = 0;
    check("cnt_clr", {cc4, cu4}, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hamming_secded_decoder_pipe.md
Name: hamming_secded_decoder_pipe

Overview:
Parametrised, pipelined Hamming SEC-DED decoder. It generalises the fixed (7,4) single-error decoder to any data width and adds an overall-parity bit for double-error detection. It performs in-place single-bit correction and uses a valid/ready stream handshake with backpressure. It sits on the receive side of a link or memory read path, directly after the codeword source.

Parameters:
DATA_W, 4, data bits per codeword; legal 4..64.
R (localparam), derived, smallest value with 2^R >= DATA_W+R+1 (4->3, 8->4, 16->5, 32->6, 64->7).
N (localparam), DATA_W+R, Hamming positions excluding overall parity; codeword width is N+1.
CNT_W, 16, error-counter width; used only with the optional feature.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  codeword valid
in_ready  output  1  decoder can accept
in_code  input  N+1  bit i-1 = Hamming position i (1..N); bit N = overall parity
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_data  output  DATA_W  corrected data
out_syndrome  output  R  raw syndrome
out_corrected  output  1  single error fixed (including a flip of the parity bit)
out_uncorrectable  output  1  double error or invalid syndrome
cnt_clr  input  1  synchronous counter clear (optional feature only)
cnt_corrected  output  CNT_W  saturating count (optional feature only)
cnt_uncorrectable  output  CNT_W  saturating count (optional feature only)

Behaviour:
- Layout: parity bits sit at power-of-two positions 1,2,4,...; data bits fill the remaining positions in ascending order, LSB first. For DATA_W=4: d0=pos3, d1=pos5, d2=pos6, d3=pos7.
- Stage 1 (registered): captures in_code, computes syndrome S (bit k = XOR of positions with bit k set) and overall parity P (XOR of all N+1 bits).
- Stage 2 (registered): applies classification and correction, drives the outputs.
- Classification:
  - S=0, P=0: clean.
  - P=1, S=0: parity bit in error; data unchanged; corrected=1.
  - P=1, 1<=S<=N: flip position S; corrected=1.
  - P=1, S>N: uncorrectable=1; data passed raw.
  - P=0, S!=0: double error; uncorrectable=1; data passed raw.
  - corrected and uncorrectable are never both 1.
- Handshake: adv = !out_valid || out_ready; in_ready = adv (combinational). When adv=1, both stages shift and stage 1 loads in_valid. When adv=0, all stage registers hold and outputs stay stable.
- Transfers occur on in_valid&&in_ready and on out_valid&&out_ready.
- Latency is 2 cycles from input acceptance to out_valid when unstalled. Throughput is 1 word per cycle. Bubbles propagate and are not collapsed.
- Reset: all valids, out_data, out_syndrome and the flags go to 0, and the counters go to 0. Reset asserted mid-stream discards in-flight words; no output is produced for them after release.
- out_data, out_syndrome and the flags are don't-care when out_valid=0, but the RTL holds their last values.

Optional Feature:
Macro HAMDEC_ERR_CNT_EN.
- Defined: cnt_corrected and cnt_uncorrectable increment by 1 on each output transfer carrying the matching flag, and saturate at all-ones without wrapping. cnt_clr zeroes both counters; if cnt_clr coincides with an increment, the clear wins.
- Undefined: cnt_clr is ignored, both counter outputs are tied to 0, and no counter flops exist.

Test Plan:
- DATA_W=4, out_ready=1, in_code=8'h55 -> 2 cycles later: out_data=4'b1011, S=0, corrected=0, uncorrectable=0.
- in_code=8'h45 (position 5 flipped) -> out_data=4'b1011, S=5, corrected=1.
- in_code=8'hD5 (overall parity flipped) -> out_data=4'b1011, S=0, corrected=1. in_code=8'h56 (positions 1 and 2 flipped) -> S=3, uncorrectable=1, corrected=0.
- Stream 8 words with out_ready low for 3 cycles mid-burst -> in_ready low while stalled, outputs held stable, all 8 words delivered in order with none lost or duplicated.
- DATA_W=32 (N=38, 39-bit code), a single flip at each of positions 1..38 -> always corrected and the data restored. Flipping positions 1 and 38 -> uncorrectable.
- rst_n pulsed low with 2 words in flight -> all outputs 0 immediately, and no out_valid after release until new input arrives. With HAMDEC_ERR_CNT_EN and CNT_W=2, 5 corrected words -> cnt_corrected=3; then cnt_clr -> 0.
